// File: rtl/i2c_codec_target_if.sv
// I2C pin bundle between a bus master (or bench) and the codec-emulating target.
// sda_i carries the resolved wired-AND level of the SDA line.
interface i2c_codec_target_if;
  logic i2c_scl_i;
  logic i2c_sda_i;
  logic i2c_sda_o;
  logic i2c_sda_t;

  modport master (
    output i2c_scl_i,
    output i2c_sda_i,
    input  i2c_sda_o,
    input  i2c_sda_t
  );

  modport slave (
    input  i2c_scl_i,
    input  i2c_sda_i,
    output i2c_sda_o,
    output i2c_sda_t
  );
endinterface

// File: rtl/i2c_codec_target.sv
// I2C target emulating the CODEC register map: oversampled SCL/SDA, register
// pointer with auto-increment, burst write/read, and a local debug read port.
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 3
) (
  input  logic               clk,
  input  logic               reset,
  i2c_codec_target_if.slave  bus,
  input  logic [7:0]         reg_rd_addr,
  output logic [7:0]         reg_rd_data,
  output logic               wr_strobe,
  output logic [7:0]         wr_addr,
  output logic [7:0]         wr_data,
  output logic               busy
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEV_ADDR = 3'd1,
    S_REG_ADDR = 3'd2,
    S_WR_DATA  = 3'd3,
    S_RD_DATA  = 3'd4,
    S_IGNORE   = 3'd5
  } state_t;

  logic          scl_meta_r, scl_sync_r, scl_filt_r, scl_prev_r;
  logic          sda_meta_r, sda_sync_r, sda_filt_r, sda_prev_r;
  logic [FW-1:0] scl_cnt_r, sda_cnt_r;

  state_t        state_r;
  logic [3:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic [AW-1:0] ptr_r;
  logic          sda_t_r;
  logic [7:0]    regs_r [NUM_REGS];

  logic          scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0]    rx_byte_s;
  logic          unused_bits_s;

  // Two-flop synchroniser, stability filter and edge-detect history for SCL/SDA.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      scl_filt_r <= 1'b1;
      scl_prev_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
      sda_filt_r <= 1'b1;
      sda_prev_r <= 1'b1;
      scl_cnt_r  <= '0;
      sda_cnt_r  <= '0;
    end else begin
      scl_meta_r <= bus.i2c_scl_i;
      scl_sync_r <= scl_meta_r;
      sda_meta_r <= bus.i2c_sda_i;
      sda_sync_r <= sda_meta_r;
      if (scl_sync_r == scl_filt_r) begin
        scl_cnt_r <= '0;
      end else if (scl_cnt_r == FW'(FILTER_LEN - 1)) begin
        scl_filt_r <= scl_sync_r;
        scl_cnt_r  <= '0;
      end else begin
        scl_cnt_r <= scl_cnt_r + FW'(1);
      end
      if (sda_sync_r == sda_filt_r) begin
        sda_cnt_r <= '0;
      end else if (sda_cnt_r == FW'(FILTER_LEN - 1)) begin
        sda_filt_r <= sda_sync_r;
        sda_cnt_r  <= '0;
      end else begin
        sda_cnt_r <= sda_cnt_r + FW'(1);
      end
      scl_prev_r <= scl_filt_r;
      sda_prev_r <= sda_filt_r;
    end
  end

  assign scl_rise_s    = scl_filt_r & ~scl_prev_r;
  assign scl_fall_s    = ~scl_filt_r & scl_prev_r;
  assign start_s       = scl_filt_r & scl_prev_r & sda_prev_r & ~sda_filt_r;
  assign stop_s        = scl_filt_r & scl_prev_r & ~sda_prev_r & sda_filt_r;
  assign rx_byte_s     = {shift_r[6:0], sda_filt_r};
  assign unused_bits_s = ^{reg_rd_addr, shift_r[7]};

  // Protocol FSM, register file, write strobe and SDA drive.
  // bit_cnt 0..7 are data bits, 8 is the ACK slot, 9 marks the ACK slot as clocked.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'h00;
      ptr_r     <= '0;
      sda_t_r   <= 1'b1;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else begin
      wr_strobe <= 1'b0;
      if (stop_s) begin
        state_r   <= S_IDLE;
        bit_cnt_r <= 4'd0;
        sda_t_r   <= 1'b1;
        busy      <= 1'b0;
      end else if (start_s) begin
        state_r   <= S_DEV_ADDR;
        bit_cnt_r <= 4'd0;
        sda_t_r   <= 1'b1;
      end else begin
        case (state_r)
          S_IDLE, S_IGNORE: begin
            sda_t_r <= 1'b1;
          end
          S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
            if (scl_rise_s) begin
              if (bit_cnt_r < 4'd8) begin
                shift_r   <= rx_byte_s;
                bit_cnt_r <= bit_cnt_r + 4'd1;
                if (bit_cnt_r == 4'd7) begin
                  case (state_r)
                    S_DEV_ADDR: begin
                      if (rx_byte_s[7:1] == DEV_ADDR) busy <= 1'b1;
                      else state_r <= S_IGNORE;
                    end
                    S_REG_ADDR: begin
                      if ({24'd0, rx_byte_s} < NUM_REGS) ptr_r <= rx_byte_s[AW-1:0];
                      else state_r <= S_IGNORE;
                    end
                    S_WR_DATA: begin
                      regs_r[ptr_r] <= rx_byte_s;
                      wr_strobe     <= 1'b1;
                      wr_addr       <= 8'(ptr_r);
                      wr_data       <= rx_byte_s;
                      ptr_r         <= ptr_r + AW'(1);
                    end
                    default: begin
                      state_r <= S_IGNORE;
                    end
                  endcase
                end
              end else begin
                bit_cnt_r <= 4'd9;
              end
            end else if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                sda_t_r <= 1'b0;
              end else if (bit_cnt_r == 4'd9) begin
                sda_t_r   <= 1'b1;
                bit_cnt_r <= 4'd0;
                case (state_r)
                  S_DEV_ADDR: begin
                    if (shift_r[0]) begin
                      state_r <= S_RD_DATA;
                      shift_r <= regs_r[ptr_r];
                      sda_t_r <= regs_r[ptr_r][7];
                    end else begin
                      state_r <= S_REG_ADDR;
                    end
                  end
                  S_REG_ADDR: state_r <= S_WR_DATA;
                  default:    state_r <= state_r;
                endcase
              end
            end
          end
          S_RD_DATA: begin
            if (scl_rise_s) begin
              if (bit_cnt_r < 4'd8) bit_cnt_r <= bit_cnt_r + 4'd1;
              else if (!sda_filt_r) bit_cnt_r <= 4'd9;
              else state_r <= S_IGNORE;
            end else if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                sda_t_r <= 1'b1;
                ptr_r   <= ptr_r + AW'(1);
              end else if (bit_cnt_r == 4'd9) begin
                bit_cnt_r <= 4'd0;
                shift_r   <= regs_r[ptr_r];
                sda_t_r   <= regs_r[ptr_r][7];
              end else if (bit_cnt_r != 4'd0) begin
                shift_r <= {shift_r[6:0], 1'b0};
                sda_t_r <= shift_r[6];
              end
            end
          end
          default: begin
            state_r <= S_IDLE;
            sda_t_r <= 1'b1;
          end
        endcase
      end
    end
  end

  // Debug read port: registered, so a same-cycle I2C write shows up one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) reg_rd_data <= 8'h00;
    else reg_rd_data <= regs_r[reg_rd_addr[AW-1:0]];
  end

  assign bus.i2c_sda_o = 1'b0;
  assign bus.i2c_sda_t = sda_t_r;
endmodule

// File: tb/tb_i2c_codec_target.sv
// Self-checking bench for i2c_codec_target: bit-banged I2C master, directed table,
// multi-cycle corner sequences and randomized transactions against a register-map model.
module tb_i2c_codec_target;
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic [7:0] reg_rd_addr, reg_rd_data, wr_addr, wr_data;
  logic       wr_strobe, busy;

  i2c_codec_target_if bus();
  assign bus.i2c_scl_i = scl_m;
  assign bus.i2c_sda_i = sda_m & (bus.i2c_sda_t | bus.i2c_sda_o);

  i2c_codec_target dut (
    .clk(clk), .reset(reset), .bus(bus), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_regs [16];
  int          ref_ptr;
  logic [15:0] exp_q[$];
  logic [15:0] strobe_q[$];
  logic [7:0]  wbuf [4];
  logic [7:0]  rbuf [4];
  logic [7:0]  rexp [4];
  bit          drove_sda, saw_busy;

  typedef struct {
    logic [7:0] dev;
    logic [7:0] rg;
    logic [7:0] d0;
    logic       dev_ack;
    logic       reg_ack;
    int         strobes;
  } vec_t;
  vec_t tbl [6];

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) strobe_q.push_back({wr_addr, wr_data});
    if (bus.i2c_sda_t === 1'b0) drove_sda = 1'b1;
    if (busy === 1'b1) saw_busy = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; tick(Q); scl_m = 1'b1; tick(2 * Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
    b = bus.i2c_sda_i;
    tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic start();
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic stop();
    sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic line;
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(line);
    ack = ~line;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      get_bit(bt);
      b[i] = bt;
    end
    put_bit(~mack);
  endtask

  task automatic master_write(input logic [7:0] dev, input logic [7:0] rg, input int n,
                              input bit do_stop, output logic [5:0] acks);
    logic a;
    acks = 6'd0;
    start();
    send_byte(dev, a); acks[0] = a;
    send_byte(rg, a);  acks[1] = a;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], a);
      acks[2 + i] = a;
    end
    if (do_stop) stop();
  endtask

  task automatic master_read(input logic [7:0] dev, input int n, input bit do_stop, output logic dev_ack);
    start();
    send_byte(dev, dev_ack);
    for (int i = 0; i < n; i++) recv_byte(i != n - 1, rbuf[i]);
    if (do_stop) stop();
  endtask

  // Register-map reference: transaction-level effect of a write/read.
  task automatic ref_write(input logic [7:0] dev, input logic [7:0] rg, input int n, output logic [5:0] acks);
    bit match, ok;
    match = (dev[7:1] == 7'h1A) && !dev[0];
    ok    = match && (rg < 8'd16);
    acks  = 6'd0;
    acks[0] = match;
    acks[1] = ok;
    if (ok) ref_ptr = int'(rg);
    for (int i = 0; i < n; i++) begin
      acks[2 + i] = ok;
      if (ok) begin
        ref_regs[ref_ptr] = wbuf[i];
        exp_q.push_back({8'(ref_ptr), wbuf[i]});
        ref_ptr = (ref_ptr + 1) % 16;
      end
    end
  endtask

  task automatic ref_read(input logic [7:0] dev, input int n, output logic dev_ack);
    dev_ack = (dev[7:1] == 7'h1A) && dev[0];
    for (int i = 0; i < n; i++) begin
      if (dev_ack) begin
        rexp[i] = ref_regs[ref_ptr];
        ref_ptr = (ref_ptr + 1) % 16;
      end else begin
        rexp[i] = 8'hFF;
      end
    end
  endtask

  task automatic rd_dbg(input logic [7:0] a, output logic [7:0] d);
    reg_rd_addr = a;
    tick(1);
    d = reg_rd_data;
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      rd_dbg(8'(i), d);
      chk(tag, 32'(d), 32'(ref_regs[i]));
    end
  endtask

  task automatic check_strobes(input string tag);
    logic [15:0] a, e;
    chk({tag, "_strobe_count"}, 32'(strobe_q.size()), 32'(exp_q.size()));
    while (strobe_q.size() > 0 && exp_q.size() > 0) begin
      a = strobe_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_strobe"}, 32'(a), 32'(e));
    end
    strobe_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [5:0] acks, eacks;
    logic [7:0] d;
    logic       a, ea, got;

    tbl[0] = '{8'h34, 8'h05, 8'hA5, 1'b1, 1'b1, 1};
    tbl[1] = '{8'h36, 8'h05, 8'h5A, 1'b0, 1'b0, 0};
    tbl[2] = '{8'h34, 8'h20, 8'h77, 1'b1, 1'b0, 0};
    tbl[3] = '{8'h34, 8'h0A, 8'h3C, 1'b1, 1'b1, 1};
    tbl[4] = '{8'h34, 8'h10, 8'h99, 1'b1, 1'b0, 0};
    tbl[5] = '{8'h34, 8'h0F, 8'hFF, 1'b1, 1'b1, 1};

    for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
    ref_ptr = 0;
    reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1; reg_rd_addr = 8'h00;
    tick(5);
    chk("rst_sda_t", 32'(bus.i2c_sda_t), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_rd_data", 32'(reg_rd_data), 32'd0);
    reset = 1'b1;
    tick(5);

    // Directed table
    for (int k = 0; k < 6; k++) begin
      drove_sda = 1'b0; saw_busy = 1'b0;
      wbuf[0] = tbl[k].d0;
      master_write(tbl[k].dev, tbl[k].rg, 1, 1'b1, acks);
      ref_write(tbl[k].dev, tbl[k].rg, 1, eacks);
      chk("tbl_acks", 32'(acks[2:0]), 32'({tbl[k].reg_ack, tbl[k].reg_ack, tbl[k].dev_ack}));
      chk("tbl_strobe_n", 32'(strobe_q.size()), 32'(tbl[k].strobes));
      check_strobes("tbl");
      chk("tbl_busy_seen", 32'(saw_busy), 32'(tbl[k].dev_ack));
      chk("tbl_busy_end", 32'(busy), 32'd0);
      if (!tbl[k].dev_ack) chk("tbl_sda_never_driven", 32'(drove_sda), 32'd0);
      rd_dbg({4'd0, tbl[k].rg[3:0]}, d);
      if (tbl[k].strobes != 0) chk("tbl_reg", 32'(d), 32'(tbl[k].d0));
      else chk("tbl_reg_kept", 32'(d), 32'(ref_regs[tbl[k].rg[3:0]]));
    end

    // Burst write with pointer wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    master_write(8'h34, 8'h0F, 2, 1'b1, acks);
    ref_write(8'h34, 8'h0F, 2, eacks);
    chk("wrap_acks", 32'(acks), 32'(eacks));
    check_strobes("wrap");
    rd_dbg(8'h0F, d); chk("wrap_reg0f", 32'(d), 32'h11);
    rd_dbg(8'h00, d); chk("wrap_reg00", 32'(d), 32'h22);

    // Set pointer, repeated START, read two bytes (ACK then NACK)
    wbuf[0] = 8'hC3; wbuf[1] = 8'hD4;
    master_write(8'h34, 8'h03, 2, 1'b1, acks);
    ref_write(8'h34, 8'h03, 2, eacks);
    check_strobes("rd_setup");
    master_write(8'h34, 8'h03, 0, 1'b0, acks);
    ref_write(8'h34, 8'h03, 0, eacks);
    chk("rd_ptr_acks", 32'(acks), 32'(eacks));
    master_read(8'h35, 2, 1'b0, a);
    ref_read(8'h35, 2, ea);
    chk("rd_dev_ack", 32'(a), 32'(ea));
    chk("rd_byte0", 32'(rbuf[0]), 32'hC3);
    chk("rd_byte1", 32'(rbuf[1]), 32'hD4);
    chk("rd_release_after_nack", 32'(bus.i2c_sda_t), 32'd1);
    chk("rd_busy_before_stop", 32'(busy), 32'd1);
    stop();
    chk("rd_busy_after_stop", 32'(busy), 32'd0);

    // STOP mid-byte discards the partial byte
    start();
    send_byte(8'h34, a); chk("mid_dev_ack", 32'(a), 32'd1);
    send_byte(8'h02, a); chk("mid_reg_ack", 32'(a), 32'd1);
    ref_write(8'h34, 8'h02, 0, eacks);
    for (int i = 0; i < 4; i++) put_bit(i[0]);
    stop();
    check_strobes("mid_stop");
    rd_dbg(8'h02, d); chk("mid_stop_reg", 32'(d), 32'(ref_regs[2]));
    // Repeated START mid-byte, then a clean write
    start();
    send_byte(8'h34, a);
    send_byte(8'h07, a);
    ref_write(8'h34, 8'h07, 0, eacks);
    put_bit(1'b1); put_bit(1'b1); put_bit(1'b0);
    wbuf[0] = 8'h6E;
    master_write(8'h34, 8'h06, 1, 1'b1, acks);
    ref_write(8'h34, 8'h06, 1, eacks);
    chk("mid_start_acks", 32'(acks), 32'(eacks));
    check_strobes("mid_start");

    // Reset while the target drives a read 0 bit
    master_write(8'h34, 8'h00, 0, 1'b0, acks);
    ref_write(8'h34, 8'h00, 0, eacks);
    start();
    send_byte(8'h35, a);
    chk("rst_rd_dev_ack", 32'(a), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (bus.i2c_sda_t === 1'b0) got = 1'b1;
      else tick(1);
    end
    chk("rst_rd_driving_low", 32'(got), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_sda_released", 32'(bus.i2c_sda_t), 32'd1);
    scl_m = 1'b1; sda_m = 1'b1;
    tick(3);
    chk("rst_busy_clear", 32'(busy), 32'd0);
    reset = 1'b1;
    tick(5);
    for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
    ref_ptr = 0;
    check_regs("rst_regs_zero");
    wbuf[0] = 8'hA5;
    master_write(8'h34, 8'h05, 1, 1'b1, acks);
    ref_write(8'h34, 8'h05, 1, eacks);
    chk("post_rst_acks", 32'(acks), 32'd7);
    check_strobes("post_rst");

    // Randomized transactions against the reference model
    for (int k = 0; k < 16; k++) begin
      logic [7:0] dev, rg;
      int n;
      n  = int'($urandom_range(1, 3));
      rg = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        dev = ($urandom_range(0, 7) == 0) ? 8'h3C : 8'h34;
        master_write(dev, rg, n, 1'b1, acks);
        ref_write(dev, rg, n, eacks);
        chk("rnd_wr_acks", 32'(acks), 32'(eacks));
        check_strobes("rnd_wr");
      end else begin
        dev = ($urandom_range(0, 7) == 0) ? 8'h3D : 8'h35;
        master_write(8'h34, rg, 0, 1'b0, acks);
        ref_write(8'h34, rg, 0, eacks);
        chk("rnd_ptr_acks", 32'(acks), 32'(eacks));
        master_read(dev, n, 1'b1, a);
        ref_read(dev, n, ea);
        chk("rnd_rd_ack", 32'(a), 32'(ea));
        for (int i = 0; i < n; i++) chk("rnd_rd_byte", 32'(rbuf[i]), 32'(rexp[i]));
      end
      chk("rnd_busy_end", 32'(busy), 32'd0);
    end
    check_regs("rnd_final_regs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
